// File: rtl/rx_hdr_filter_pkg.sv
// rtl/rx_hdr_filter_pkg.sv - shared types and constants for the receive header filter
//
// Contents:
//   rx_state_t  packet framing state (FIRST, HDR, PASS, DROP)
//   BCAST_MAC   broadcast destination address, always accepted by the filter
//   MAC_MSB/LSB position of the destination MAC inside the first beat
//   HDR_CNT_W   width of the header beat counter (covers 0..15)
//   mac_reject  destination-MAC filter decision
package rx_hdr_filter_pkg;

   typedef enum logic [1:0] {
      ST_FIRST = 2'd0,
      ST_HDR   = 2'd1,
      ST_PASS  = 2'd2,
      ST_DROP  = 2'd3
   } rx_state_t;

   localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
   localparam int          MAC_MSB   = 95;
   localparam int          MAC_LSB   = 48;
   localparam int          HDR_CNT_W = 4;

   // A packet is rejected only when filtering is on and the destination is
   // neither this node nor broadcast.
   function automatic logic mac_reject(input logic [47:0] dst,
                                       input logic [47:0] local_mac,
                                       input logic        filter_en);
      return filter_en && (dst != local_mac) && (dst != BCAST_MAC);
   endfunction

endpackage

// File: rtl/rx_hdr_filter_if.sv
// rtl/rx_hdr_filter_if.sv - AXI-stream style bundle used on both sides of the filter
//
// Signals:
//   tdata  [DATA_W]  payload
//   tkeep  [KEEP_W]  byte enables
//   tvalid           beat valid (source to sink)
//   tlast            last beat of packet
//   tuser  [USER_W]  sideband
//   tready           sink can accept (sink to source)
// Modports:
//   master  source side (drives payload/valid, reads ready)
//   slave   sink side   (reads payload/valid, drives ready)
interface rx_hdr_filter_if #(
   parameter int DATA_W = 128,
   parameter int KEEP_W = DATA_W / 8,
   parameter int USER_W = 4
) ();

   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic              tvalid;
   logic              tlast;
   logic [USER_W-1:0] tuser;
   logic              tready;

   modport master (output tdata, output tkeep, output tvalid, output tlast,
                   output tuser, input tready);

   modport slave  (input tdata, input tkeep, input tvalid, input tlast,
                   input tuser, output tready);

endinterface

// File: rtl/axis_skid_reg.sv
// rtl/axis_skid_reg.sv - one-entry registered AXI-stream slice
//
// Ports:
//   user_clk, reset        clock, synchronous active-high reset
//   in_t*                  upstream beat (data/keep/last/user/valid), in_tready back
//   out_t*                 registered beat to downstream, out_tready in
// The slice accepts a new beat whenever it is empty or is being drained in
// the same cycle, so a held-high out_tready gives one beat per cycle.
module axis_skid_reg #(
   parameter int DATA_W = 128,
   parameter int KEEP_W = DATA_W / 8,
   parameter int USER_W = 4
) (
   input  logic              user_clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_tdata,
   input  logic [KEEP_W-1:0] in_tkeep,
   input  logic              in_tlast,
   input  logic [USER_W-1:0] in_tuser,
   input  logic              in_tvalid,
   output logic              in_tready,
   output logic [DATA_W-1:0] out_tdata,
   output logic [KEEP_W-1:0] out_tkeep,
   output logic              out_tlast,
   output logic [USER_W-1:0] out_tuser,
   output logic              out_tvalid,
   input  logic              out_tready
);

   assign in_tready = !out_tvalid || out_tready;

   // Payload only moves when the slice can take a beat, which keeps the
   // outputs frozen while the downstream stalls.
   always_ff @(posedge user_clk) begin
      if (reset) begin
         out_tvalid <= 1'b0;
         out_tdata  <= '0;
         out_tkeep  <= '0;
         out_tlast  <= 1'b0;
         out_tuser  <= '0;
      end else if (in_tready) begin
         out_tvalid <= in_tvalid;
         if (in_tvalid) begin
            out_tdata <= in_tdata;
            out_tkeep <= in_tkeep;
            out_tlast <= in_tlast;
            out_tuser <= in_tuser;
         end
      end
   end

endmodule

// File: rtl/rx_hdr_filter.sv
// rtl/rx_hdr_filter.sv - strips header beats and drops unwanted packets on the receive path
//
// Ports:
//   user_clk, reset   clock, synchronous active-high reset
//   s_axis            stream from the router (slave side)
//   m_axis            stream to the transport layer (master side), registered
//   local_mac         this node's MAC, sampled on the first beat of each packet
//   rx_dst_mac_addr   destination MAC of the most recent first beat
//   pkt_fwd_cnt       saturating count of packets leaving with m_axis.tlast
//   pkt_drop_cnt      saturating count of dropped packets (flagged, filtered, runt)
module rx_hdr_filter
   import rx_hdr_filter_pkg::*;
#(
   parameter int DATA_W        = 128,
   parameter int KEEP_W        = DATA_W / 8,
   parameter int USER_W        = 4,
   parameter int HDR_BEATS     = 1,
   parameter int DROP_BIT      = 2,
   parameter bit MAC_FILTER_EN = 1'b1,
   parameter int CNT_W         = 32
) (
   input  logic             user_clk,
   input  logic             reset,
   rx_hdr_filter_if.slave   s_axis,
   rx_hdr_filter_if.master  m_axis,
   input  logic [47:0]      local_mac,
   output logic [47:0]      rx_dst_mac_addr,
   output logic [CNT_W-1:0] pkt_fwd_cnt,
   output logic [CNT_W-1:0] pkt_drop_cnt
);

   // Value hdr_cnt holds while the final header beat is being consumed.
   localparam logic [HDR_CNT_W-1:0] HDR_LAST =
      HDR_CNT_W'((HDR_BEATS == 0) ? 0 : HDR_BEATS - 1);

   rx_state_t             state_q, state_d;
   logic [HDR_CNT_W-1:0]  hdr_cnt_q, hdr_cnt_d;
   logic [USER_W-1:0]     tuser_q;
   logic [47:0]           first_dst;
   logic                  pkt_reject;
   logic                  beat_acc;
   logic                  fwd_beat;
   logic                  drop_pkt;
   logic                  fwd_done;
   logic                  skid_in_ready;
   logic                  skid_in_tvalid;
   logic [USER_W-1:0]     skid_in_tuser;

   assign first_dst  = s_axis.tdata[MAC_MSB:MAC_LSB];
   assign pkt_reject = s_axis.tuser[DROP_BIT] ||
                       mac_reject(first_dst, local_mac, MAC_FILTER_EN);

   // Header and discarded beats never reach the slice, so they are sunk
   // regardless of downstream backpressure.
   assign s_axis.tready = skid_in_ready || (state_q == ST_HDR) || (state_q == ST_DROP);
   assign beat_acc      = s_axis.tvalid && s_axis.tready;

   always_comb begin
      state_d   = state_q;
      hdr_cnt_d = hdr_cnt_q;
      fwd_beat  = 1'b0;
      drop_pkt  = 1'b0;
      if (beat_acc) begin
         unique case (state_q)
            ST_FIRST: begin
               if (pkt_reject) begin
                  state_d  = s_axis.tlast ? ST_FIRST : ST_DROP;
                  drop_pkt = s_axis.tlast;
               end else if (HDR_BEATS >= 2) begin
                  // A packet ending inside its header is a runt.
                  state_d   = s_axis.tlast ? ST_FIRST : ST_HDR;
                  hdr_cnt_d = HDR_CNT_W'(1);
                  drop_pkt  = s_axis.tlast;
               end else if (HDR_BEATS == 1) begin
                  state_d  = s_axis.tlast ? ST_FIRST : ST_PASS;
                  drop_pkt = s_axis.tlast;
               end else begin
                  fwd_beat = 1'b1;
                  state_d  = s_axis.tlast ? ST_FIRST : ST_PASS;
               end
            end
            ST_HDR: begin
               hdr_cnt_d = hdr_cnt_q + 1'b1;
               if (s_axis.tlast) begin
                  state_d  = ST_FIRST;
                  drop_pkt = 1'b1;
               end else if (hdr_cnt_q == HDR_LAST) begin
                  state_d = ST_PASS;
               end
            end
            ST_PASS: begin
               fwd_beat = 1'b1;
               if (s_axis.tlast) state_d = ST_FIRST;
            end
            ST_DROP: begin
               if (s_axis.tlast) begin
                  state_d  = ST_FIRST;
                  drop_pkt = 1'b1;
               end
            end
            default: state_d = ST_FIRST;
         endcase
      end
   end

   always_ff @(posedge user_clk) begin
      if (reset) begin
         state_q         <= ST_FIRST;
         hdr_cnt_q       <= '0;
         tuser_q         <= '0;
         rx_dst_mac_addr <= '0;
      end else begin
         state_q   <= state_d;
         hdr_cnt_q <= hdr_cnt_d;
         if (beat_acc && (state_q == ST_FIRST)) begin
            tuser_q         <= s_axis.tuser;
            rx_dst_mac_addr <= first_dst;
         end
      end
   end

   // With no header stripping the first beat is forwarded before tuser_q
   // has been loaded, so it takes its sideband straight from the input.
   assign skid_in_tvalid = beat_acc && fwd_beat;
   assign skid_in_tuser  = (state_q == ST_FIRST) ? s_axis.tuser : tuser_q;

   axis_skid_reg #(
      .DATA_W (DATA_W),
      .KEEP_W (KEEP_W),
      .USER_W (USER_W)
   ) u_skid (
      .user_clk   (user_clk),
      .reset      (reset),
      .in_tdata   (s_axis.tdata),
      .in_tkeep   (s_axis.tkeep),
      .in_tlast   (s_axis.tlast),
      .in_tuser   (skid_in_tuser),
      .in_tvalid  (skid_in_tvalid),
      .in_tready  (skid_in_ready),
      .out_tdata  (m_axis.tdata),
      .out_tkeep  (m_axis.tkeep),
      .out_tlast  (m_axis.tlast),
      .out_tuser  (m_axis.tuser),
      .out_tvalid (m_axis.tvalid),
      .out_tready (m_axis.tready)
   );

   assign fwd_done = m_axis.tvalid && m_axis.tready && m_axis.tlast;

   always_ff @(posedge user_clk) begin
      if (reset) begin
         pkt_fwd_cnt  <= '0;
         pkt_drop_cnt <= '0;
      end else begin
         if (fwd_done && (pkt_fwd_cnt != {CNT_W{1'b1}}))
            pkt_fwd_cnt <= pkt_fwd_cnt + 1'b1;
         if (drop_pkt && (pkt_drop_cnt != {CNT_W{1'b1}}))
            pkt_drop_cnt <= pkt_drop_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_rx_hdr_filter.sv
// tb/tb_rx_hdr_filter.sv - self-checking bench for rx_hdr_filter (one and two header beats)
module tb_rx_hdr_filter;

   localparam int          DW    = 128;
   localparam int          KW    = 16;
   localparam int          UW    = 4;
   localparam logic [47:0] LMAC  = 48'h0200_0000_0001;
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
      logic [UW-1:0] u;
   } beat_t;

   logic        user_clk = 1'b0;
   logic        reset    = 1'b1;
   logic [47:0] local_mac;
   logic [47:0] dst_a, dst_b;
   logic [31:0] fwd_a, drop_a;
   logic [1:0]  fwd_b, drop_b;

   int    errors = 0;
   int    checks = 0;
   int    rmode  = 0;
   beat_t qa[$];
   beat_t qb[$];
   longint exp_fwd[2];
   longint exp_drop[2];
   logic [DW-1:0] pd[16];
   logic [KW-1:0] pk[16];

   rx_hdr_filter_if #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) sa ();
   rx_hdr_filter_if #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) ma ();
   rx_hdr_filter_if #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) sb ();
   rx_hdr_filter_if #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) mb ();

   rx_hdr_filter #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW), .HDR_BEATS(1),
                   .DROP_BIT(2), .MAC_FILTER_EN(1'b1), .CNT_W(32)) dut_a (
      .user_clk(user_clk), .reset(reset), .s_axis(sa), .m_axis(ma),
      .local_mac(local_mac), .rx_dst_mac_addr(dst_a),
      .pkt_fwd_cnt(fwd_a), .pkt_drop_cnt(drop_a));

   rx_hdr_filter #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW), .HDR_BEATS(2),
                   .DROP_BIT(2), .MAC_FILTER_EN(1'b1), .CNT_W(2)) dut_b (
      .user_clk(user_clk), .reset(reset), .s_axis(sb), .m_axis(mb),
      .local_mac(local_mac), .rx_dst_mac_addr(dst_b),
      .pkt_fwd_cnt(fwd_b), .pkt_drop_cnt(drop_b));

   initial forever #5 user_clk = ~user_clk;

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // m_tready pattern: 0 always high, 1 toggling, 2 random, 3 held low
   initial begin
      logic r;
      r = 1'b1;
      ma.tready = 1'b1;
      mb.tready = 1'b1;
      forever begin
         @(posedge user_clk);
         #1;
         case (rmode)
            0:       r = 1'b1;
            1:       r = ~r;
            2:       r = 1'(($urandom_range(0, 1)));
            default: r = 1'b0;
         endcase
         ma.tready = r;
         mb.tready = r;
      end
   end

   task automatic score(input int w, input beat_t got);
      beat_t e;
      if (w == 0) begin
         chk("a_beat_expected", qa.size() != 0, 1'b1);
         if (qa.size() != 0) begin
            e = qa.pop_front();
            chk("a_out_beat", got, e);
         end
      end else begin
         chk("b_beat_expected", qb.size() != 0, 1'b1);
         if (qb.size() != 0) begin
            e = qb.pop_front();
            chk("b_out_beat", got, e);
         end
      end
   endtask

   initial begin
      bit    stall;
      beat_t snap, cur;
      stall = 1'b0;
      forever begin
         @(negedge user_clk);
         cur = {ma.tdata, ma.tkeep, ma.tlast, ma.tuser};
         if (reset) stall = 1'b0;
         else begin
            if (stall) begin
               chk("a_stall_tvalid", ma.tvalid, 1'b1);
               chk("a_stall_hold", cur, snap);
            end
            if (ma.tvalid && ma.tready) score(0, cur);
            stall = ma.tvalid && !ma.tready;
            snap  = cur;
         end
      end
   end

   initial begin
      bit    stall;
      beat_t snap, cur;
      stall = 1'b0;
      forever begin
         @(negedge user_clk);
         cur = {mb.tdata, mb.tkeep, mb.tlast, mb.tuser};
         if (reset) stall = 1'b0;
         else begin
            if (stall) begin
               chk("b_stall_tvalid", mb.tvalid, 1'b1);
               chk("b_stall_hold", cur, snap);
            end
            if (mb.tvalid && mb.tready) score(1, cur);
            stall = mb.tvalid && !mb.tready;
            snap  = cur;
         end
      end
   end

   // Packet-level reference: a packet is either dropped as a whole (flagged,
   // filtered, or too short to outlive its header) or loses its first hb beats.
   task automatic model_pkt(input int w, input int len, input logic [3:0] tu, input logic [47:0] dst);
      int     hb;
      longint cap;
      bit     rej;
      beat_t  b;
      hb  = (w == 0) ? 1 : 2;
      cap = (w == 0) ? 64'hFFFF_FFFF : 64'd3;
      rej = tu[2] || ((dst != local_mac) && (dst != BCAST));
      if (rej || len <= hb) begin
         if (exp_drop[w] < cap) exp_drop[w]++;
      end else begin
         for (int i = hb; i < len; i++) begin
            b.d = pd[i];
            b.k = pk[i];
            b.l = (i == len - 1);
            b.u = tu;
            if (w == 0) qa.push_back(b);
            else qb.push_back(b);
         end
         if (exp_fwd[w] < cap) exp_fwd[w]++;
      end
   endtask

   task automatic sync();
      @(posedge user_clk);
      #1;
   endtask

   task automatic idle();
      sa.tvalid = 1'b0;
      sb.tvalid = 1'b0;
   endtask

   // Sends beats [0, stop) of a len-beat packet; a truncated packet is not modelled.
   task automatic send_pkt(input int w, input int len, input logic [3:0] tu, input logic [47:0] dst,
                           input bit flip, input bit chk_rdy, input int stop);
      logic [47:0] saved;
      bit          acc;
      int          n;
      saved = local_mac;
      for (int i = 0; i < len; i++) begin
         pd[i] = {$urandom, $urandom, $urandom, $urandom};
         pk[i] = (i == len - 1) ? 16'($urandom) : 16'hFFFF;
      end
      pd[0][95:48] = dst;
      if (stop >= len) model_pkt(w, len, tu, dst);
      for (int i = 0; i < len && i < stop; i++) begin
         sa.tdata  = pd[i];  sb.tdata  = pd[i];
         sa.tkeep  = pk[i];  sb.tkeep  = pk[i];
         sa.tlast  = (i == len - 1);
         sb.tlast  = (i == len - 1);
         sa.tuser  = tu;     sb.tuser  = tu;
         sa.tvalid = (w == 0);
         sb.tvalid = (w == 1);
         acc = 1'b0;
         n   = 0;
         while (!acc && n < 200) begin
            @(negedge user_clk);
            acc = (w == 0) ? sa.tready : sb.tready;
            if (chk_rdy) chk("drop_s_tready", acc, 1'b1);
            @(posedge user_clk);
            #1;
            n++;
         end
         if (!acc) chk("accept_in_budget", acc, 1'b1);
         if (i == 0 && flip) local_mac = {$urandom, 16'($urandom)};
      end
      local_mac = saved;
   endtask

   task automatic drain();
      int n;
      idle();
      n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 400) begin
         sync();
         n++;
      end
      repeat (3) sync();
      @(negedge user_clk);
      chk("drain_a_empty", qa.size(), 0);
      chk("drain_b_empty", qb.size(), 0);
      chk("idle_a_m_tvalid", ma.tvalid, 1'b0);
      chk("fwd_cnt_a", fwd_a, exp_fwd[0]);
      chk("drop_cnt_a", drop_a, exp_drop[0]);
      chk("fwd_cnt_b", fwd_b, exp_fwd[1]);
      chk("drop_cnt_b", drop_b, exp_drop[1]);
      sync();
   endtask

   function automatic logic [47:0] pick_dst();
      case ($urandom_range(0, 2))
         0:       return LMAC;
         1:       return BCAST;
         default: return {$urandom, 16'($urandom)};
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      local_mac = LMAC;
      exp_fwd   = '{0, 0};
      exp_drop  = '{0, 0};
      idle();
      sa.tdata = '0; sa.tkeep = '0; sa.tlast = 1'b0; sa.tuser = '0;
      sb.tdata = '0; sb.tkeep = '0; sb.tlast = 1'b0; sb.tuser = '0;
      repeat (3) @(posedge user_clk);
      #1 reset = 1'b0;

      @(negedge user_clk);
      chk("rst_a_m_tvalid", ma.tvalid, 1'b0);
      chk("rst_a_s_tready", sa.tready, 1'b1);
      chk("rst_a_m_tdata", ma.tdata, '0);
      chk("rst_a_m_tuser", ma.tuser, '0);
      chk("rst_a_m_tlast", ma.tlast, 1'b0);
      chk("rst_a_dst", dst_a, '0);
      chk("rst_a_fwd", fwd_a, '0);
      chk("rst_a_drop", drop_a, '0);
      chk("rst_b_m_tvalid", mb.tvalid, 1'b0);
      chk("rst_b_s_tready", sb.tready, 1'b1);
      sync();

      send_pkt(0, 4, 4'h1, LMAC, 1'b0, 1'b0, 99);
      drain();
      chk("t1_dst_latched", dst_a, LMAC);

      send_pkt(0, 4, 4'h4, LMAC, 1'b0, 1'b1, 99);
      drain();

      send_pkt(0, 3, 4'h0, 48'h0200_0000_0009, 1'b0, 1'b0, 99);
      send_pkt(0, 3, 4'h2, BCAST, 1'b0, 1'b0, 99);
      drain();
      chk("t3_dst_bcast", dst_a, BCAST);

      rmode = 1;
      repeat (6) send_pkt(0, 3, 4'($urandom) & 4'hB, LMAC, 1'b0, 1'b0, 99);
      rmode = 0;
      drain();

      rmode = 2;
      for (int i = 0; i < 12; i++)
         send_pkt(0, $urandom_range(1, 6), 4'($urandom), pick_dst(), i == 3, 1'b0, 99);
      rmode = 0;
      drain();

      send_pkt(1, 2, 4'h0, LMAC, 1'b0, 1'b0, 99);
      drain();
      send_pkt(1, 5, 4'h1, LMAC, 1'b0, 1'b0, 99);
      drain();

      rmode = 2;
      for (int i = 0; i < 10; i++)
         send_pkt(1, $urandom_range(1, 6), 4'($urandom), pick_dst(), 1'b0, 1'b0, 99);
      rmode = 0;
      for (int i = 0; i < 5; i++) send_pkt(1, 3, 4'h8, BCAST, 1'b0, 1'b0, 99);
      for (int i = 0; i < 5; i++) send_pkt(1, 2, 4'h0, LMAC, 1'b0, 1'b0, 99);
      drain();

      rmode = 3;
      sync();
      sync();
      send_pkt(0, 4, 4'h3, LMAC, 1'b0, 1'b0, 2);
      idle();
      @(negedge user_clk);
      chk("pre_rst_m_tvalid", ma.tvalid, 1'b1);
      sync();
      reset = 1'b1;
      sync();
      reset = 1'b0;
      qa.delete();
      qb.delete();
      exp_fwd  = '{0, 0};
      exp_drop = '{0, 0};
      @(negedge user_clk);
      chk("post_rst_m_tvalid", ma.tvalid, 1'b0);
      chk("post_rst_fwd", fwd_a, '0);
      chk("post_rst_drop", drop_a, '0);
      chk("post_rst_dst", dst_a, '0);
      rmode = 0;
      sync();
      sync();
      send_pkt(0, 3, 4'h1, BCAST, 1'b0, 1'b0, 99);
      drain();
      chk("post_rst_new_dst", dst_a, BCAST);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rx_hdr_filter.md
Name: rx_hdr_filter

Overview:
- Parameterised receive-side framing block between the router AXI-stream output and the transport layer input.
- Per packet: captures the first-beat tuser and destination MAC, then strips a configurable number of leading header beats.
- Drops whole packets that are flagged by tuser or fail the destination-MAC filter, and forwards the remaining beats through a registered skid stage.
- Keeps saturating forwarded/dropped packet counters.

Parameters:
- DATA_W, 128, stream data width in bits (multiple of 64, minimum 128).
- KEEP_W, DATA_W/8, byte-enable width.
- USER_W, 4, sideband user width.
- HDR_BEATS, 1, leading beats per packet consumed and not forwarded (0..15).
- DROP_BIT, 2, tuser bit index that marks a packet for discard.
- MAC_FILTER_EN, 1, enables the destination-MAC check when 1.
- CNT_W, 32, statistics counter width.

Ports:
- user_clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_tdata  in  DATA_W  data from router
- s_tkeep  in  KEEP_W  byte enables from router
- s_tvalid  in  1  valid from router
- s_tlast  in  1  last beat from router
- s_tready  out  1  ready to router
- s_tuser  in  USER_W  packet sideband, meaningful on the first beat only
- local_mac  in  48  this node's MAC address, quasi-static
- m_tdata  out  DATA_W  data to transport
- m_tkeep  out  KEEP_W  byte enables to transport
- m_tvalid  out  1  valid to transport
- m_tlast  out  1  last beat to transport
- m_tuser  out  USER_W  latched first-beat tuser, held for every beat of the packet
- m_tready  in  1  ready from transport
- rx_dst_mac_addr  out  48  destination MAC latched from tdata[95:48] of the first beat
- pkt_fwd_cnt  out  CNT_W  count of packets forwarded with m_tlast
- pkt_drop_cnt  out  CNT_W  count of packets dropped

Behaviour:
- Reset values: all outputs 0, except s_tready = 1 when the skid stage is empty. FSM goes to FIRST.
- Input beat accepted when s_tvalid & s_tready.
- s_tready = skid stage can take a beat (stage empty, or m_tready asserted), or the FSM is in HDR or DROP. Beats in HDR and DROP are always sunk, independent of m_tready.
- States: FIRST, HDR, PASS, DROP.
- FIRST, on an accepted beat:
  - Latch tuser_q ← s_tuser and rx_dst_mac_addr ← s_tdata[95:48].
  - drop = s_tuser[DROP_BIT] | (MAC_FILTER_EN & dst ≠ local_mac & dst ≠ 48'hFFFF_FFFF_FFFF).
  - If drop: go to DROP, or stay in FIRST and count the drop if s_tlast.
  - Else if HDR_BEATS ≥ 2: go to HDR with hdr_cnt = 1.
  - Else if HDR_BEATS = 1: go to PASS. The beat is not forwarded.
  - Else (HDR_BEATS = 0): forward the beat and go to PASS.
  - In every case, s_tlast on this beat returns the FSM to FIRST.
- HDR: each accepted beat increments hdr_cnt. When hdr_cnt reaches HDR_BEATS−1, go to PASS.
- Runt packet: s_tlast during FIRST-with-strip or HDR returns to FIRST and increments pkt_drop_cnt. No output is produced.
- PASS: accepted beats are written to the skid stage with m_tuser = tuser_q. An accepted s_tlast returns to FIRST.
- DROP: beats are sunk. An accepted s_tlast increments pkt_drop_cnt and returns to FIRST.
- Output latency: one cycle from acceptance to m_tvalid. Outputs are registered; no combinational path from s_* to m_*.
- m_* hold stable while m_tvalid & !m_tready.
- Full throughput: one beat per cycle with m_tready held high.
- pkt_fwd_cnt increments on m_tvalid & m_tready & m_tlast.
- Both counters saturate at all-ones and do not wrap.
- Simultaneous FIRST beat and skid drain: both occur in the same cycle, with no bubble.
- local_mac is sampled only on the first beat. A change mid-packet does not affect the current packet.
- Reset mid-packet:
  - The skid stage is flushed without emitting m_tlast.
  - The FSM returns to FIRST.
  - The next accepted beat is treated as a first beat.
  - Counters are cleared.

Decomposition:
- Shared package: state encoding (FIRST, HDR, PASS, DROP), broadcast MAC constant, MAC field bit offsets (95:48).
- Sub-module: axis_skid_reg, a one-entry registered AXI-stream slice parameterised by DATA_W, KEEP_W, USER_W, holding data/keep/last/user.

Test Plan:
- HDR_BEATS=1, MAC_FILTER_EN=1, local_mac=02:00:00:00:00:01: 4-beat packet to that MAC with tuser=4'h1, m_tready=1 → 3 beats out, m_tuser=4'h1 on each, m_tlast on the 3rd, pkt_fwd_cnt=1.
- Same configuration, 4-beat packet with tuser[2]=1 → no m_tvalid, s_tready held 1 for all 4 beats, pkt_drop_cnt=1.
- Packet to dst 02:00:00:00:00:09, then a packet to FF:FF:FF:FF:FF:FF → first dropped, second forwarded; both counters = 1.
- Back-to-back 3-beat packets with m_tready toggling 1010… → output order and data preserved, no beat lost or duplicated, m_* stable while stalled.
- HDR_BEATS=2, 2-beat runt packet → no output, pkt_drop_cnt=1. Next 5-beat packet → 3 beats out.
- Reset asserted for 1 cycle after beat 2 of a 4-beat forwarded packet → m_tvalid=0 the following cycle, counters 0. The next packet's first beat latches a new rx_dst_mac_addr.
